// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// ARB_CPU_PRIORITY_EN selects CPU-priority tie breaking instead of round-robin.
package sram_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

`ifdef ARB_CPU_PRIORITY_EN
   localparam logic CPU_PRIORITY = 1'b1;
`else
   localparam logic CPU_PRIORITY = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

endpackage

// File: rtl/sram_arbiter_pick2.sv
// Combinational two-way winner selection (pick1=1 means requester 1 wins).
// Tie rule follows ARB_CPU_PRIORITY_EN through sram_arb_pkg::CPU_PRIORITY.
module arb_pick2
   import sram_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   input  logic force1,
   output logic pick1
);

   // Winner select; on a tie round-robin favours the requester not served last
   always_comb begin
      pick1 = 1'b0;
      if (req0 && req1) begin
         pick1 = force1 | (~CPU_PRIORITY & ~last_gnt);
      end else if (req1) begin
         pick1 = 1'b1;
      end else begin
         pick1 = 1'b0;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter: IDLE -> ACCESS -> COMPLETE FSM.
// ARB_CPU_PRIORITY_EN adds CPU priority with a bounded starvation counter.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              We0,
   input  logic              We1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] Wdata0,
   input  logic [DATA_W-1:0] Wdata1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Rvalid0,
   output logic              Rvalid1,
   output logic [DATA_W-1:0] Rdata,
   output logic              SRAMRead,
   output logic              SRAMWrite,
   output logic [ADDR_W-1:0] SRAMAddress,
   output logic [DATA_W-1:0] SRAMDatain,
   input  logic [DATA_W-1:0] SRAMDataout
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                rd_q, rd_d, wr_q, wr_d;
   logic                rv0_q, rv0_d, rv1_q, rv1_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   rdata_s;
   logic                arb_s, pick1_s, force1_s, we_s;

   arb_pick2 u_pick (
      .req0     (Req0),
      .req1     (Req1),
      .last_gnt (last_q),
      .force1   (force1_s),
      .pick1    (pick1_s)
   );

`ifdef ARB_CPU_PRIORITY_EN
   logic [3:0] wait_q, wait_d;

   assign force1_s = (wait_q == WAIT_LIM);

   // Starvation counter: counts ties lost by requester 1, cleared by its grant
   always_comb begin
      wait_d = wait_q;
      if (arb_s && pick1_s) begin
         wait_d = 4'd0;
      end else if (arb_s && Req0 && Req1) begin
         wait_d = wait_q + 4'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         wait_q <= 4'd0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   // MAX_WAIT is 1..15, so round-robin never forces requester 1
   assign force1_s = (WAIT_LIM == 4'd0);
`endif

   // Read data passes through in COMPLETE and is held otherwise
   assign rdata_s = (rv0_q | rv1_q) ? SRAMDataout : rdata_q;

   // Next-state, arbitration and output decode
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      rv0_d   = 1'b0;
      rv1_d   = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_s;
      arb_s   = 1'b0;
      we_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               state_d = ACCESS;
               arb_s   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = COMPLETE;
            rv0_d   = rd_q & ~last_q;
            rv1_d   = rd_q & last_q;
         end
         COMPLETE: begin
            if (Req0 || Req1) begin
               state_d = ACCESS;
               arb_s   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The winner's controls are captured on the edge entering ACCESS
      if (arb_s) begin
         we_s   = pick1_s ? We1 : We0;
         last_d = pick1_s;
         gnt0_d = ~pick1_s;
         gnt1_d = pick1_s;
         wr_d   = we_s;
         rd_d   = ~we_s;
         addr_d = pick1_s ? Addr1 : Addr0;
         din_d  = pick1_s ? Wdata1 : Wdata0;
      end else begin
         last_d = last_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rv0_q   <= rv0_d;
         rv1_q   <= rv1_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
      end
   end

   assign Gnt0        = gnt0_q;
   assign Gnt1        = gnt1_q;
   assign Rvalid0     = rv0_q;
   assign Rvalid1     = rv1_q;
   assign Rdata       = rdata_s;
   assign SRAMRead    = rd_q;
   assign SRAMWrite   = wr_q;
   assign SRAMAddress = addr_q;
   assign SRAMDatain  = din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model.
// Tie expectations follow ARB_CPU_PRIORITY_EN when it is defined.
module tb_sram_arbiter;

   logic       clk;
   logic       Reset;
   logic       Req0, Req1, We0, We1;
   logic [7:0] Addr0, Addr1, Wdata0, Wdata1;
   logic       Gnt0, Gnt1, Rvalid0, Rvalid1;
   logic [7:0] Rdata;
   logic       SRAMRead, SRAMWrite;
   logic [7:0] SRAMAddress, SRAMDatain, SRAMDataout;

   logic [7:0] mem [256];
   int         n_vec;
   int         n_err;
   logic [9:0] tie_seq;

   sram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
      .clk(clk), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
      .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
      .Rdata(Rdata), .SRAMRead(SRAMRead), .SRAMWrite(SRAMWrite),
      .SRAMAddress(SRAMAddress), .SRAMDatain(SRAMDatain),
      .SRAMDataout(SRAMDataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: synchronous write, read data one cycle after SRAMRead
   always @(posedge clk) begin
      if (SRAMWrite) mem[SRAMAddress] <= SRAMDatain;
      if (SRAMRead) SRAMDataout <= mem[SRAMAddress];
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      Reset = 1'b1;
      Req0 = 1'b0; Req1 = 1'b0; We0 = 1'b0; We1 = 1'b0;
      Addr0 = 8'h00; Addr1 = 8'h00; Wdata0 = 8'h00; Wdata1 = 8'h00;
`ifdef ARB_CPU_PRIORITY_EN
      tie_seq = 10'b1000010000;
`else
      tie_seq = 10'b1010101010;
`endif
      repeat (2) step();
      check_val("rst_ctl", 8'({Gnt0, Gnt1, Rvalid0, Rvalid1, SRAMRead, SRAMWrite}), 8'h00);
      check_val("rst_addr", SRAMAddress, 8'h00);
      check_val("rst_din", SRAMDatain, 8'h00);
      check_val("rst_rdata", Rdata, 8'h00);
      Reset = 1'b0;

      // Scenario 1: preload 0x5A at 0x10, then read it back
      Req0 = 1'b1; We0 = 1'b1; Addr0 = 8'h10; Wdata0 = 8'h5A;
      step();
      check_val("s1w_gnt", 8'({Gnt0, Gnt1}), 8'h02);
      check_val("s1w_strb", 8'({SRAMRead, SRAMWrite}), 8'h01);
      check_val("s1w_din", SRAMDatain, 8'h5A);
      Req0 = 1'b0;
      step();
      check_val("s1w_norv", 8'({Rvalid0, Rvalid1}), 8'h00);
      step();
      Req0 = 1'b1; We0 = 1'b0;
      step();
      check_val("s1r_gnt", 8'({Gnt0, Gnt1}), 8'h02);
      check_val("s1r_strb", 8'({SRAMRead, SRAMWrite}), 8'h02);
      check_val("s1r_addr", SRAMAddress, 8'h10);
      Req0 = 1'b0;
      step();
      check_val("s1r_rv", 8'({Rvalid0, Rvalid1}), 8'h02);
      check_val("s1r_rdata", Rdata, 8'h5A);
      check_val("s1r_nostrb", 8'({SRAMRead, SRAMWrite}), 8'h00);
      step();
      check_val("s1_rvdrop", 8'({Rvalid0, Rvalid1}), 8'h00);
      check_val("s1_rdhold", Rdata, 8'h5A);
      check_val("s1_addrhold", SRAMAddress, 8'h10);

      // Scenarios 2/3: both writers held high, grant order per tie rule
      do_reset();
      Req0 = 1'b1; Req1 = 1'b1; We0 = 1'b1; We1 = 1'b1;
      Addr0 = 8'h20; Addr1 = 8'h30; Wdata0 = 8'hA0; Wdata1 = 8'hB1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k % 2 == 0) begin
            check_val("tie_gnt", 8'({Gnt0, Gnt1}), tie_seq[k/2] ? 8'h01 : 8'h02);
            check_val("tie_din", SRAMDatain, tie_seq[k/2] ? 8'hB1 : 8'hA0);
            check_val("tie_wr", 8'({SRAMRead, SRAMWrite}), 8'h01);
         end else begin
            check_val("tie_gap", 8'({Gnt0, Gnt1, SRAMRead, SRAMWrite, Rvalid0, Rvalid1}), 8'h00);
         end
      end
      Req0 = 1'b0; Req1 = 1'b0;
      step();

      // Scenario 5: lone Req1 read stream, no IDLE gap
      Req1 = 1'b1; We1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("s5_gnt", 8'({Gnt0, Gnt1}), (k % 2 == 0) ? 8'h01 : 8'h00);
         check_val("s5_rv", 8'({Rvalid0, Rvalid1}), (k % 2 == 1) ? 8'h01 : 8'h00);
         if (k % 2 == 1) check_val("s5_rdata", Rdata, 8'hB1);
      end

      // Scenario 4: reset in the middle of a Req1 read access
      step();
      check_val("s4_gnt", 8'({Gnt1, SRAMRead}), 8'h03);
      Reset = 1'b1;
      #1;
      check_val("s4_drop", 8'({Gnt0, Gnt1, SRAMRead, SRAMWrite, Rvalid0, Rvalid1}), 8'h00);
      check_val("s4_addr", SRAMAddress, 8'h00);
      check_val("s4_rdata", Rdata, 8'h00);
      Req1 = 1'b0;
      step();
      Reset = 1'b0;
      step();
      check_val("s4_norv_a", 8'({Rvalid0, Rvalid1, Gnt0, Gnt1}), 8'h00);
      step();
      check_val("s4_norv_b", 8'({Rvalid0, Rvalid1, Gnt0, Gnt1}), 8'h00);
      Req0 = 1'b1; We0 = 1'b0; Addr0 = 8'h20;
      Req1 = 1'b1; We1 = 1'b0; Addr1 = 8'h30;
      step();
      check_val("s4_tie", 8'({Gnt0, Gnt1}), 8'h02);
      Req0 = 1'b0;
      step();
      check_val("s4_rv0", 8'({Rvalid0, Rvalid1}), 8'h02);
      check_val("s4_rd0", Rdata, 8'hA0);
      step();
      check_val("s6_gnt1", 8'({Gnt0, Gnt1}), 8'h01);
      Req1 = 1'b0;

      // Scenario 6: Req0 raised during COMPLETE of the Req1 read
      step();
      check_val("s6_rv1", 8'({Rvalid0, Rvalid1}), 8'h01);
      check_val("s6_rd1", Rdata, 8'hB1);
      Req0 = 1'b1;
      step();
      check_val("s6_gnt0", 8'({Gnt0, Gnt1}), 8'h02);
      check_val("s6_addr", SRAMAddress, 8'h20);
      Req0 = 1'b0;
      step();
      check_val("s6_rv0", 8'({Rvalid0, Rvalid1}), 8'h02);
      check_val("s6_rd0", Rdata, 8'hA0);
      step();
      check_val("s6_idle", 8'({Gnt0, Gnt1, Rvalid0, Rvalid1, SRAMRead, SRAMWrite}), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
